// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and the stream FSM state type
// shared by vga_stream_out and its timing counter.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int line_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF      = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF      = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running horizontal/vertical raster counters with combinational
// active-area, sync and frame-origin decodes.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hs_n_o,
  output logic             vs_n_o,
  output logic             frame_start_o
);

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == H_MAX);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign active_o      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_n_o        = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
  assign vs_n_o        = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_stream_out.sv
// Avalon-ST 12-bit RGB pixel stream to VGA conduit: locks to sop at the raster
// origin, blanks any frame with underflow or framing errors and relocks next frame.
module vga_stream_out
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [11:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic        vga_out_CLK,
  output logic        vga_out_HS,
  output logic        vga_out_VS,
  output logic        vga_out_BLANK,
  output logic        vga_out_SYNC,
  output logic [3:0]  vga_out_R,
  output logic [3:0]  vga_out_G,
  output logic [3:0]  vga_out_B,
  input  logic        stat_clear,
  output logic        stat_underflow,
  output logic        stat_frame_err,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, hs_n, vs_n, origin, last;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk_i         (clk_clk),
    .rst_ni        (reset_reset_n),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .active_o      (active),
    .hs_n_o        (hs_n),
    .vs_n_o        (vs_n),
    .frame_start_o (origin)
  );

  assign last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  state_e      state_q, state_d;
  logic        ready, show, uf_set, fe_set;
  logic        hs_q, vs_q, blank_q, fs_q;
  logic        uf_q, uf_d, fe_q, fe_d;
  logic [11:0] rgb_q, rgb_d;

  // In WAIT a sop is held off until the origin so it lines up with (0,0);
  // anything else is drained. In RUN the stream is consumed only when visible.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    show    = 1'b0;
    uf_set  = 1'b0;
    fe_set  = 1'b0;
    unique case (state_q)
      WAIT: begin
        ready = origin | ~in_sop;
        if (origin && in_valid && in_sop) begin
          show    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        ready = active;
        if (active) begin
          if (!in_valid) begin
            uf_set  = 1'b1;
            state_d = WAIT;
          end else if ((in_sop && !origin) || (in_eop != last)) begin
            fe_set  = 1'b1;
            state_d = WAIT;
          end else begin
            show = 1'b1;
          end
        end
      end
      default: state_d = WAIT;
    endcase
  end

  assign rgb_d = show ? in_data : 12'h000;
  assign uf_d  = uf_set | (uf_q & ~stat_clear);
  assign fe_d  = fe_set | (fe_q & ~stat_clear);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= WAIT;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= 12'h000;
      uf_q    <= 1'b0;
      fe_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_n;
      vs_q    <= vs_n;
      blank_q <= active;
      rgb_q   <= rgb_d;
      uf_q    <= uf_d;
      fe_q    <= fe_d;
      fs_q    <= origin;
    end
  end

  // Gated by reset so the source sees no handshake while the block is held.
  assign in_ready       = ready & reset_reset_n;
  assign vga_out_CLK    = ~clk_clk;
  assign vga_out_HS     = hs_q;
  assign vga_out_VS     = vs_q;
  assign vga_out_BLANK  = blank_q;
  assign vga_out_SYNC   = 1'b0;
  assign vga_out_R      = rgb_q[11:8];
  assign vga_out_G      = rgb_q[7:4];
  assign vga_out_B      = rgb_q[3:0];
  assign stat_underflow = uf_q;
  assign stat_frame_err = fe_q;
  assign frame_start    = fs_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a reduced raster: a raster-position model derived
// from the cycle count predicts every pin each cycle, plus literal anchors.
module tb_vga_stream_out;

  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam int NPIX = HA * VA;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [11:0] in_data = 12'h000;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, stat_clear = 1'b0;
  logic        in_ready, vga_out_CLK, vga_out_HS, vga_out_VS, vga_out_BLANK, vga_out_SYNC;
  logic [3:0]  vga_out_R, vga_out_G, vga_out_B;
  logic        stat_underflow, stat_frame_err, frame_start;

  always #5 clk_clk = ~clk_clk;

  vga_stream_out #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP)
  ) dut (
    .clk_clk (clk_clk), .reset_reset_n (reset_reset_n),
    .in_data (in_data), .in_valid (in_valid), .in_sop (in_sop), .in_eop (in_eop),
    .in_ready (in_ready), .vga_out_CLK (vga_out_CLK), .vga_out_HS (vga_out_HS),
    .vga_out_VS (vga_out_VS), .vga_out_BLANK (vga_out_BLANK), .vga_out_SYNC (vga_out_SYNC),
    .vga_out_R (vga_out_R), .vga_out_G (vga_out_G), .vga_out_B (vga_out_B),
    .stat_clear (stat_clear), .stat_underflow (stat_underflow),
    .stat_frame_err (stat_frame_err), .frame_start (frame_start)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, epoch = 0, src_idx = 0;
  bit have_exp = 1'b0, rel_pending = 1'b0, m_run = 1'b0, m_uf = 1'b0, m_fe = 1'b0;
  bit inject = 1'b0;
  logic [19:0] exp_pack = '0;
  int rdy_cnt[16], hs_lo[16], vs_lo[16], vis_nz[16];
  int fs_t[$];
  int unsigned tab[16][NPIX];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cyc %0d epoch %0d)", name, act, req, cyc, epoch);
  endtask

  function automatic bit is_rand(input int fa);
    return (fa == 3) || (fa == 4) || (fa == 7);
  endfunction

  function automatic bit clear_at(input int fa, input int p);
    return (fa == 5 && p == 2) || (fa == 7 && p == 3) ||
           (fa == 7 && p == 6*HT + 2) || (fa == 8 && p == 40);
  endfunction

  task automatic drive_inputs();
    int p, fa, x, y;
    int unsigned r;
    p  = cyc % FR;
    fa = epoch*10 + cyc / FR;
    x  = src_idx % HA;
    y  = src_idx / HA;
    r  = tab[fa % 16][src_idx];
    in_valid   = 1'b1;
    in_sop     = (src_idx == 0);
    in_eop     = (src_idx == NPIX - 1);
    in_data    = is_rand(fa) ? r[11:0] : {x[3:0], y[3:0], 4'hA};
    stat_clear = clear_at(fa, p);
    inject     = 1'b0;
    if (epoch == 0 && fa == 3 && p == 3*HT + 9) in_valid = 1'b0;
    if (epoch == 0 && fa == 7 && p == 6*HT + 2) in_valid = 1'b0;
    if (epoch == 0 && fa == 5 && p == 5) begin
      in_sop  = 1'b1;
      in_eop  = 1'b0;
      in_data = 12'h5A5;
      inject  = 1'b1;
    end
  endtask

  task automatic model_step();
    int p, fa, h, v;
    bit act, origin, last, er, acc, show, uf, fe, hs_e, vs_e;
    p      = cyc % FR;
    fa     = epoch*10 + cyc / FR;
    h      = p % HT;
    v      = p / HT;
    act    = (h < HA) && (v < VA);
    origin = (p == 0);
    last   = (h == HA - 1) && (v == VA - 1);
    er     = m_run ? act : (origin || !in_sop);
    chk("in_ready", 32'(in_ready), 32'(er));
    if (in_ready) rdy_cnt[fa]++;
    acc  = in_valid && er;
    show = 1'b0; uf = 1'b0; fe = 1'b0;
    if (!m_run) begin
      if (origin && acc && in_sop) begin show = 1'b1; m_run = 1'b1; end
    end else if (act) begin
      if (!in_valid) uf = 1'b1;
      else if ((in_sop && !origin) || (in_eop && !last) || (last && !in_eop)) fe = 1'b1;
      else show = 1'b1;
      if (uf || fe) m_run = 1'b0;
    end
    m_uf = uf ? 1'b1 : (stat_clear ? 1'b0 : m_uf);
    m_fe = fe ? 1'b1 : (stat_clear ? 1'b0 : m_fe);
    hs_e = !(h >= HA + HFP && h < HA + HFP + HSW);
    vs_e = !(v >= VA + VFP && v < VA + VFP + VSW);
    exp_pack = {1'b1, hs_e, vs_e, act, 1'b0, (show ? in_data : 12'h000), m_uf, m_fe, origin};
    if (acc && !inject) src_idx = (src_idx + 1) % NPIX;
    have_exp = 1'b1;
    cyc++;
  endtask

  task automatic compare_outputs();
    int q, fa;
    logic [11:0] rgb;
    q   = cyc - 1;
    fa  = epoch*10 + q / FR;
    rgb = {vga_out_R, vga_out_G, vga_out_B};
    chk("pins", 32'({vga_out_CLK, vga_out_HS, vga_out_VS, vga_out_BLANK, vga_out_SYNC, rgb,
                     stat_underflow, stat_frame_err, frame_start}), 32'(exp_pack));
    if (!vga_out_HS) hs_lo[fa]++;
    if (!vga_out_VS) vs_lo[fa]++;
    if (vga_out_BLANK && rgb != 12'h000) vis_nz[fa]++;
    if (frame_start && epoch == 0) fs_t.push_back(q);
    if (q == 0) chk("fs_first", 32'(frame_start), 32'd1);
    if (q == 2*HT + 3) chk("pix_3_2", 32'(rgb), 32'h32A);
    if (epoch == 0) begin
      if (q == 3*FR - 1) chk("flags_clean", 32'({stat_underflow, stat_frame_err}), 32'd0);
      if (q == 3*FR + 3*HT + 9)
        chk("uf_pixel", 32'({vga_out_BLANK, rgb, stat_underflow}), 32'h2001);
      if (q == 5*FR + 5) chk("fe_set", 32'({stat_underflow, stat_frame_err}), 32'd1);
      if (q == 7*FR + 6*HT + 2)
        chk("clear_vs_set", 32'({stat_underflow, stat_frame_err}), 32'd2);
      if (q == 8*FR + 40) chk("clear_alone", 32'(stat_underflow), 32'd0);
    end
  endtask

  task automatic do_cycle();
    @(negedge clk_clk);
    if (rel_pending) begin
      reset_reset_n = 1'b1;
      rel_pending   = 1'b0;
      cyc           = 0;
      have_exp      = 1'b0;
    end
    if (have_exp) compare_outputs();
    drive_inputs();
    #1;
    model_step();
  endtask

  task automatic run_to(input int t);
    while (cyc < t) do_cycle();
  endtask

  task automatic chk_reset_pins(input string name);
    chk(name, 32'({vga_out_CLK, vga_out_HS, vga_out_VS, vga_out_BLANK, vga_out_SYNC,
                   vga_out_R, vga_out_G, vga_out_B, stat_underflow, stat_frame_err,
                   frame_start, in_ready}), 32'({3'b111, 18'h0}));
  endtask

  initial begin
    foreach (tab[i, j]) tab[i][j] = $urandom;
    repeat (3) @(negedge clk_clk);
    #1 chk_reset_pins("reset_init");
    rel_pending = 1'b1;
    do_cycle();
    run_to(8*FR + 5*HT + 10);
    // Asynchronous reset in the middle of a visible line of a locked frame
    @(negedge clk_clk);
    compare_outputs();
    reset_reset_n = 1'b0;
    #1 chk_reset_pins("reset_async");
    repeat (2) @(negedge clk_clk);
    #1 chk_reset_pins("reset_hold");
    epoch = 1; m_run = 1'b0; m_uf = 1'b0; m_fe = 1'b0; src_idx = 0;
    have_exp = 1'b0; rel_pending = 1'b1;
    do_cycle();
    run_to(FR + 2);

    foreach (rdy_cnt[f]) begin
      if (f == 0 || f == 1 || f == 2 || f == 4 || f == 6 || f == 10)
        chk($sformatf("ready_per_frame[%0d]", f), 32'(rdy_cnt[f]), 32'd128);
      if (f <= 7 || f == 10) begin
        chk($sformatf("hs_low[%0d]", f), 32'(hs_lo[f]), 32'd60);
        chk($sformatf("vs_low[%0d]", f), 32'(vs_lo[f]), 32'd50);
      end
    end
    chk("visible_before_err", 32'(vis_nz[5]), 32'd5);
    chk("fs_count", 32'(fs_t.size()), 32'd9);
    for (int i = 1; i < fs_t.size(); i++)
      chk($sformatf("fs_spacing[%0d]", i), 32'(fs_t[i] - fs_t[i-1]), 32'd375);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_stream_out.md
# vga_stream_out

- Converts a 12-bit RGB Avalon-ST pixel stream into 640x480@60 VGA timing and drives the `vga_out_*` conduit of the trivia system.
- Sits between the frame-buffer reader (SDRAM side) and the board VGA DAC pins.
- Locks to the stream on start-of-packet and generates all sync and blanking.
- Detects underflow and framing errors; blacks out the bad frame and resynchronises on the next frame.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width in lines

Ports (one clock; reset is asynchronous and active-low; clk_clk is the 25 MHz pixel clock):
- clk_clk  in  1  pixel clock
- reset_reset_n  in  1  async active-low reset
- in_data  in  12  pixel {R[3:0],G[3:0],B[3:0]}
- in_valid  in  1  beat valid
- in_sop  in  1  first pixel of frame
- in_eop  in  1  last pixel of frame
- in_ready  out  1  beat accepted when in_valid && in_ready
- vga_out_CLK  out  1  DAC clock, equals ~clk_clk; the only combinational output
- vga_out_HS, vga_out_VS  out  1 each  active-low syncs
- vga_out_BLANK  out  1  active-low blank: 1 = visible pixel
- vga_out_SYNC  out  1  constant 0
- vga_out_R, vga_out_G, vga_out_B  out  4 each  colour
- stat_clear  in  1  single-cycle pulse; clears the sticky flags
- stat_underflow  out  1  sticky: active pixel with no valid beat
- stat_frame_err  out  1  sticky: sop/eop in the wrong position
- frame_start  out  1  one-cycle pulse when h=0, v=0

## Operation
Counters:
- h_cnt runs 0..799 and wraps.
- v_cnt increments when h_cnt wraps; it runs 0..524 and wraps.
- active = h_cnt < 640 && v_cnt < 480.
- HS is low for h_cnt 656..751; VS is low for v_cnt 490..491.

State machine (WAIT, RUN; reset state is WAIT):
- WAIT, outside (0,0): in_ready = ~in_sop. Non-sop beats are drained and discarded; a sop beat is held off.
- WAIT, at h=0, v=0: in_ready = 1. If in_valid && in_sop, the pixel is displayed and the state goes to RUN; otherwise stay in WAIT.
- RUN: in_ready = active.
  - Each active cycle with in_valid displays in_data.
  - Active cycle with !in_valid: display black, set stat_underflow, go to WAIT.
  - Accepted in_sop at a position other than (0,0): set stat_frame_err, go to WAIT; the beat is discarded.
  - The accepted beat at (639,479) must carry in_eop. If it does not, set stat_frame_err and go to WAIT.
  - in_eop accepted earlier than (639,479): set stat_frame_err, go to WAIT.
- Any pixel not displayed from the stream (WAIT, blanking, error) outputs RGB = 0.
- in_ready depends on in_sop only in WAIT. It never depends on in_valid.
- Sticky flags:
  - stat_clear in the same cycle as a set event: the set wins.
  - Flags change only via a set event or stat_clear.

## Timing
- All pin outputs except vga_out_CLK are registered.
- Sync, blank and colour for counter position (h,v) at cycle n appear at cycle n+1; pixel latency is one clock.
- Reset values:
  - HS=1, VS=1, BLANK=0, SYNC=0, RGB=0
  - in_ready=0 during reset
  - stat_* = 0, frame_start = 0
  - h_cnt = 0, v_cnt = 0, state WAIT
- Reset deassertion: the first counted cycle is (0,0). A sop presented then is accepted.
- Reset mid-frame: outputs return to reset values asynchronously. The current frame is abandoned and the block waits for the next sop at (0,0).
- Line period is 800 clocks; frame period is 420000 clocks.

## Structure
- vga_timing_pkg holds:
  - the default timing constants
  - the derived H_TOTAL/V_TOTAL and sync start/end positions
  - the state enum {WAIT, RUN}
- Sub-module vga_timing_counter holds the counters and produces the signals below; the top holds the stream FSM and output registers:
  - h_cnt, v_cnt
  - active, hs_n, vs_n
  - frame_start
- Counter widths: 10 bits each.

## Test plan
- Reset, then a clean 640x480 frame (pixel = {x[3:0],y[3:0],4'hA}) with no stalls:
  - pins show RGB one cycle after each accept
  - HS low 96 clocks per line; VS low 1600 clocks
  - no flags set
- Two back-to-back clean frames: RUN is held, in_ready is high exactly 307200 cycles per frame, and frame_start pulses at 420000-cycle spacing.
- in_valid dropped at x=100, y=10:
  - that pixel is black and stat_underflow = 1
  - stale beats are drained in WAIT
  - display resumes at the next frame's sop
- Sop injected at x=5, y=0 of frame 2: stat_frame_err = 1, the remainder of the frame is black, and the block relocks on frame 3.
- stat_clear pulsed in the same cycle as an underflow event: the flag stays 1. A later clear with no event clears it.
- reset_reset_n asserted at x=300, y=200:
  - outputs take reset values immediately
  - after release, the bench sends a fresh frame and it displays correctly from (0,0)
